// File: rtl/main_memory_pkg.sv
// Shared definitions for the multi-port burst main memory: burst size
// encodings, beat-count decode and the per-port FSM state type.
package main_memory_pkg;

  localparam int WORD_BYTES = 4;

  localparam logic [1:0] SZ_1  = 2'b00;
  localparam logic [1:0] SZ_4  = 2'b01;
  localparam logic [1:0] SZ_8  = 2'b10;
  localparam logic [1:0] SZ_16 = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  function automatic logic [4:0] burst_beats(input logic [1:0] size);
    case (size)
      SZ_1:    return 5'd1;
      SZ_4:    return 5'd4;
      SZ_8:    return 5'd8;
      SZ_16:   return 5'd16;
      default: return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/main_memory_mp_port.sv
// One burst access port: FSM, beat address counter, range check and the
// registered read/status outputs. Issues one beat request per cycle.
module mem_burst_port
  import main_memory_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
  parameter int          DEPTH_BYTES = 1024,
  parameter int          IDX_W       = 8
) (
  input  logic             i_clock,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_read_not_write,
  input  logic [1:0]       i_access_size,
  input  logic [31:0]      i_address,
  input  logic [31:0]      i_data_in,
  input  logic [3:0]       i_byte_en,
  input  logic [31:0]      i_rdata,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_we,
  output logic [3:0]       o_be,
  output logic [31:0]      o_wdata,
  output logic [31:0]      o_data_out,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_error
);

  state_e      r_state;
  logic [4:0]  r_beats_left;
  logic [31:0] r_addr;
  logic        r_rnw;
  logic [31:0] r_data_out;
  logic        r_valid;
  logic        r_busy;
  logic        r_error;

  logic        w_active;
  logic        w_rnw;
  logic [31:0] w_addr;
  logic [31:0] w_offset;
  logic        w_in_range;
  logic [4:0]  w_beats;

  // Current beat: the in-flight burst owns the port, otherwise a new command.
  always_comb begin
    w_active = 1'b0;
    w_rnw    = r_rnw;
    w_addr   = r_addr;
    if (r_state == ST_BURST) begin
      w_active = 1'b1;
    end else if (i_enable) begin
      w_active = 1'b1;
      w_rnw    = i_read_not_write;
      w_addr   = i_address & 32'hFFFF_FFFC;
    end else begin
      w_active = 1'b0;
    end
    // Unsigned wrap makes addresses below the base land out of range too.
    w_offset   = w_addr - BASE_ADDR;
    w_in_range = (w_offset < 32'(DEPTH_BYTES));
    w_beats    = burst_beats(i_access_size);
    o_idx      = w_offset[IDX_W+1:2];
    o_we       = w_active && !w_rnw && w_in_range && i_rst;
    o_be       = i_byte_en;
    o_wdata    = i_data_in;
  end

  always_ff @(posedge i_clock) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_beats_left <= 5'd0;
      r_addr       <= 32'd0;
      r_rnw        <= 1'b0;
      r_data_out   <= 32'd0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_valid <= w_active && w_rnw;
      r_error <= w_active && !w_in_range;
      if (w_active && w_rnw) begin
        r_data_out <= w_in_range ? i_rdata : 32'd0;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_enable && (w_beats > 5'd1)) begin
            r_state      <= ST_BURST;
            r_busy       <= 1'b1;
            r_beats_left <= w_beats - 5'd1;
            r_addr       <= w_addr + 32'd4;
            r_rnw        <= i_read_not_write;
          end
        end
        ST_BURST: begin
          r_addr       <= r_addr + 32'd4;
          r_beats_left <= r_beats_left - 5'd1;
          if (r_beats_left == 5'd1) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data_out = r_data_out;
  assign o_valid    = r_valid;
  assign o_busy     = r_busy;
  assign o_error    = r_error;

endmodule

// File: rtl/main_memory_mp.sv
// Multi-port burst main memory: shared word array behind NPORTS independent
// burst ports, per-byte highest-port-wins writes and read-first reads.
module main_memory_mp
  import main_memory_pkg::*;
#(
  parameter int          NPORTS      = 2,
  parameter int          DEPTH_BYTES = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8002_0000
) (
  input  logic                    i_clock,
  input  logic                    i_rst,
  input  logic [NPORTS-1:0]       i_enable,
  input  logic [NPORTS-1:0]       i_read_not_write,
  input  logic [NPORTS-1:0][1:0]  i_access_size,
  input  logic [NPORTS-1:0][31:0] i_address,
  input  logic [NPORTS-1:0][31:0] i_data_in,
  input  logic [NPORTS-1:0][3:0]  i_byte_en,
  output logic [NPORTS-1:0][31:0] o_data_out,
  output logic [NPORTS-1:0]       o_valid,
  output logic [NPORTS-1:0]       o_busy,
  output logic [NPORTS-1:0]       o_error
);

  localparam int WORDS = DEPTH_BYTES / WORD_BYTES;
  localparam int IDX_W = $clog2(WORDS);

  logic [31:0]      r_mem [WORDS];
  logic [IDX_W-1:0] w_idx   [NPORTS];
  logic             w_we    [NPORTS];
  logic [3:0]       w_be    [NPORTS];
  logic [31:0]      w_wdata [NPORTS];
  logic [31:0]      w_rdata [NPORTS];

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    // Combinational read sees the pre-edge contents, giving read-first.
    assign w_rdata[g] = r_mem[w_idx[g]];

    mem_burst_port #(
      .BASE_ADDR  (BASE_ADDR),
      .DEPTH_BYTES(DEPTH_BYTES),
      .IDX_W      (IDX_W)
    ) u_port (
      .i_clock         (i_clock),
      .i_rst           (i_rst),
      .i_enable        (i_enable[g]),
      .i_read_not_write(i_read_not_write[g]),
      .i_access_size   (i_access_size[g]),
      .i_address       (i_address[g]),
      .i_data_in       (i_data_in[g]),
      .i_byte_en       (i_byte_en[g]),
      .i_rdata         (w_rdata[g]),
      .o_idx           (w_idx[g]),
      .o_we            (w_we[g]),
      .o_be            (w_be[g]),
      .o_wdata         (w_wdata[g]),
      .o_data_out      (o_data_out[g]),
      .o_valid         (o_valid[g]),
      .o_busy          (o_busy[g]),
      .o_error         (o_error[g])
    );
  end

  // Later ports' assignments override earlier ones, so the highest port wins per byte.
  always_ff @(posedge i_clock) begin
    for (int p = 0; p < NPORTS; p++) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (w_we[p] && w_be[p][b]) begin
          r_mem[w_idx[p]][8*b +: 8] <= w_wdata[p][8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_main_memory_mp.sv
// Directed self-checking bench for main_memory_mp (2 ports, 1 KiB at 0x80020000).
module tb_main_memory_mp;
  import main_memory_pkg::*;

  localparam logic [31:0] BASE = 32'h8002_0000;

  logic             clk;
  logic             rst;
  logic [1:0]       en;
  logic [1:0]       rnw;
  logic [1:0][1:0]  sz;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] din;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] dout;
  logic [1:0]       vld;
  logic [1:0]       bsy;
  logic [1:0]       err;

  int n_chk  = 0;
  int n_pass = 0;

  main_memory_mp #(.NPORTS(2), .DEPTH_BYTES(1024), .BASE_ADDR(BASE)) dut (
    .i_clock(clk), .i_rst(rst), .i_enable(en), .i_read_not_write(rnw),
    .i_access_size(sz), .i_address(addr), .i_data_in(din), .i_byte_en(be),
    .o_data_out(dout), .o_valid(vld), .o_busy(bsy), .o_error(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    int          port;
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    en   = 2'b00;
    rnw  = 2'b11;
    sz   = '0;
    be   = '0;
    din  = '0;
  endtask

  task automatic cmd(input int p, input logic r, input logic [1:0] s,
                     input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    en[p]   = 1'b1;
    rnw[p]  = r;
    sz[p]   = s;
    addr[p] = a;
    din[p]  = d;
    be[p]   = b;
  endtask

  initial begin
    int cnt_busy;
    int cnt_valid;
    addr = '0;
    idle();

    // Reset held two cycles with commands requested on both ports.
    rst = 1'b0;
    cmd(0, 1'b1, SZ_16, BASE, 32'd0, 4'hF);
    cmd(1, 1'b1, SZ_16, BASE, 32'd0, 4'hF);
    step();
    step();
    chk("rst_busy",  {30'd0, bsy}, 32'd0);
    chk("rst_valid", {30'd0, vld}, 32'd0);
    chk("rst_error", {30'd0, err}, 32'd0);
    chk("rst_dout0", dout[0], 32'd0);
    chk("rst_dout1", dout[1], 32'd0);
    rst = 1'b1;
    idle();
    step();

    // 16-beat write burst on port 0.
    cnt_busy  = 0;
    cnt_valid = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) cmd(0, 1'b0, SZ_16, BASE, 32'h100, 4'hF);
      else begin
        en[0]  = 1'b0;
        din[0] = 32'h100 + 32'(i);
      end
      step();
      if (bsy[0]) cnt_busy++;
      if (vld[0]) cnt_valid++;
    end
    chk("wr16_busy_cycles", 32'(cnt_busy), 32'd15);
    chk("wr16_valid_cycles", 32'(cnt_valid), 32'd0);
    chk("wr16_busy_end", {31'd0, bsy[0]}, 32'd0);
    idle();

    // 4-beat read back-to-back with a 1-beat read.
    cmd(0, 1'b1, SZ_4, BASE + 32'h10, 32'd0, 4'h0);
    step();
    en[0] = 1'b0;
    chk("rd4_valid0", {31'd0, vld[0]}, 32'd1);
    chk("rd4_data0", dout[0], 32'h104);
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("rd4_valid%0d", k), {31'd0, vld[0]}, 32'd1);
      chk($sformatf("rd4_data%0d", k), dout[0], 32'h104 + 32'(k));
    end
    chk("rd4_busy_end", {31'd0, bsy[0]}, 32'd0);
    cmd(0, 1'b1, SZ_1, BASE, 32'd0, 4'h0);
    step();
    chk("b2b_valid", {31'd0, vld[0]}, 32'd1);
    chk("b2b_data", dout[0], 32'h100);
    idle();
    step();
    chk("b2b_valid_drop", {31'd0, vld[0]}, 32'd0);
    chk("b2b_data_hold", dout[0], 32'h100);

    // Single-beat vectors: byte enables, no-op writes, range and alias checks.
    vt[0]  = '{0, 1'b0, 32'h8002_0040, 32'h1122_3344, 4'hF, 1'b0, 32'h0,         1'b0};
    vt[1]  = '{0, 1'b0, 32'h8002_0040, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0,         1'b0};
    vt[2]  = '{0, 1'b1, 32'h8002_0040, 32'h0,         4'h0, 1'b1, 32'h11BB_33DD, 1'b0};
    vt[3]  = '{0, 1'b0, 32'h8002_0044, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0,         1'b0};
    vt[4]  = '{0, 1'b0, 32'h8002_0044, 32'hDEAD_BEEF, 4'h0, 1'b0, 32'h0,         1'b0};
    vt[5]  = '{1, 1'b1, 32'h8002_0044, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D, 1'b0};
    vt[6]  = '{0, 1'b0, 32'h0000_0000, 32'h1234_5678, 4'hF, 1'b0, 32'h0,         1'b1};
    vt[7]  = '{0, 1'b1, 32'h8002_0000, 32'h0,         4'h0, 1'b1, 32'h0000_0100, 1'b0};
    vt[8]  = '{0, 1'b1, 32'h8002_0400, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1};
    vt[9]  = '{1, 1'b0, 32'h8002_03FC, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0,         1'b0};
    vt[10] = '{1, 1'b0, 32'h8002_03F8, 32'h0F0F_0F0F, 4'hF, 1'b0, 32'h0,         1'b0};
    vt[11] = '{0, 1'b1, 32'h8002_03FF, 32'h0,         4'h0, 1'b1, 32'h0BAD_F00D, 1'b0};
    vt[12] = '{0, 1'b1, 32'h8002_0043, 32'h0,         4'h0, 1'b1, 32'h11BB_33DD, 1'b0};
    vt[13] = '{1, 1'b1, 32'h7FFF_FFFC, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1};
    for (int i = 0; i < 14; i++) begin
      idle();
      cmd(vt[i].port, vt[i].rnw, SZ_1, vt[i].addr, vt[i].data, vt[i].be);
      step();
      chk($sformatf("vec%0d_valid", i), {31'd0, vld[vt[i].port]}, {31'd0, vt[i].exp_valid});
      chk($sformatf("vec%0d_error", i), {31'd0, err[vt[i].port]}, {31'd0, vt[i].exp_err});
      chk($sformatf("vec%0d_busy", i), {30'd0, bsy}, 32'd0);
      if (vt[i].exp_valid) chk($sformatf("vec%0d_data", i), dout[vt[i].port], vt[i].exp_data);
    end
    idle();
    step();
    chk("oor_err_pulse", {30'd0, err}, 32'd0);

    // 8-beat read crossing the top of memory: 2 good beats then 6 errors.
    cmd(0, 1'b1, SZ_8, BASE + 32'd1024 - 32'd8, 32'd0, 4'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      en[0] = 1'b0;
      chk($sformatf("edge_valid%0d", k), {31'd0, vld[0]}, 32'd1);
      chk($sformatf("edge_error%0d", k), {31'd0, err[0]}, (k < 2) ? 32'd0 : 32'd1);
      chk($sformatf("edge_data%0d", k), dout[0],
          (k == 0) ? 32'h0F0F_0F0F : (k == 1) ? 32'h0BAD_F00D : 32'd0);
    end
    step();
    chk("edge_valid_end", {31'd0, vld[0]}, 32'd0);
    chk("edge_error_end", {31'd0, err[0]}, 32'd0);

    // Same-word collisions: full-word, per-byte, and read-first.
    idle();
    cmd(0, 1'b0, SZ_1, BASE + 32'h20, 32'hAAAA_AAAA, 4'hF);
    cmd(1, 1'b0, SZ_1, BASE + 32'h20, 32'h5555_5555, 4'hF);
    step();
    idle();
    cmd(0, 1'b1, SZ_1, BASE + 32'h20, 32'd0, 4'h0);
    step();
    chk("coll_word", dout[0], 32'h5555_5555);
    idle();
    cmd(0, 1'b0, SZ_1, BASE + 32'h20, 32'hAAAA_AAAA, 4'hF);
    cmd(1, 1'b0, SZ_1, BASE + 32'h20, 32'h5555_5555, 4'h3);
    step();
    idle();
    cmd(0, 1'b1, SZ_1, BASE + 32'h20, 32'd0, 4'h0);
    step();
    chk("coll_bytes", dout[0], 32'hAAAA_5555);
    idle();
    cmd(0, 1'b1, SZ_1, BASE + 32'h20, 32'd0, 4'h0);
    cmd(1, 1'b0, SZ_1, BASE + 32'h20, 32'h1234_5678, 4'hF);
    step();
    chk("read_first_old", dout[0], 32'hAAAA_5555);
    idle();
    cmd(0, 1'b1, SZ_1, BASE + 32'h20, 32'd0, 4'h0);
    step();
    chk("read_first_new", dout[0], 32'h1234_5678);

    // A command presented mid-burst is ignored.
    idle();
    cmd(0, 1'b1, SZ_4, BASE + 32'h10, 32'd0, 4'h0);
    step();
    chk("ign_data0", dout[0], 32'h104);
    chk("ign_busy", {31'd0, bsy[0]}, 32'd1);
    cmd(0, 1'b0, SZ_16, BASE, 32'hFFFF_FFFF, 4'hF);
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("ign_valid%0d", k), {31'd0, vld[0]}, 32'd1);
      chk($sformatf("ign_data%0d", k), dout[0], 32'h104 + 32'(k));
    end
    idle();
    cmd(0, 1'b1, SZ_1, BASE, 32'd0, 4'h0);
    step();
    chk("ign_word0", dout[0], 32'h100);

    // Reset mid-burst aborts it; array contents survive.
    idle();
    cmd(0, 1'b1, SZ_8, BASE, 32'd0, 4'h0);
    step();
    idle();
    chk("abort_beat0", dout[0], 32'h100);
    step();
    chk("abort_beat1", dout[0], 32'h101);
    rst = 1'b0;
    step();
    chk("abort_busy", {31'd0, bsy[0]}, 32'd0);
    chk("abort_valid", {31'd0, vld[0]}, 32'd0);
    chk("abort_dout", dout[0], 32'd0);
    rst = 1'b1;
    cnt_valid = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (vld[0] || bsy[0]) cnt_valid++;
    end
    chk("abort_no_beats", 32'(cnt_valid), 32'd0);
    cmd(0, 1'b1, SZ_1, BASE, 32'd0, 4'h0);
    step();
    chk("retain_word0", dout[0], 32'h100);
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
